// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, constants, converter state encoding and the
// field-pack helper used wherever an fp16 word is assembled.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int EXP_BIAS = 15;
    // Biased exponent of a 16-bit magnitude whose MSB sits at bit 15.
    localparam int MAX_EXP  = EXP_BIAS + 15;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } conv_state_e;

    function automatic logic [15:0] fp16_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even of a 10-bit fp16 mantissa given guard and sticky bits.
// A carry out of the mantissa bumps the exponent and leaves the mantissa zero.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic [EXP_W-1:0]  exp,
    input  logic              guard,
    input  logic              sticky,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              inexact
);

    logic              round_up;
    logic [MANT_W:0]   sum;

    always_comb begin
        round_up = guard & (sticky | mant[0]);
        sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        mant_out = sum[MANT_W-1:0];
        exp_out  = exp + {{(EXP_W-1){1'b0}}, sum[MANT_W]};
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/int16_to_fp16_serial.sv
// Serial int16 -> fp16 converter: one normalising shift per cycle, then a
// single RNE rounding cycle that registers the packed result.
module int16_to_fp16_serial
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_int,
    output logic [15:0] o_res,
    output logic        o_res_vld,
    output logic        o_inexact
);

    conv_state_e        state;
    logic               sign;
    logic               zero;
    logic [15:0]        mag;
    logic [EXP_W-1:0]   exp_r;

    logic [MANT_W-1:0]  rnd_mant;
    logic [EXP_W-1:0]   rnd_exp;
    logic               rnd_inexact;

    // Hidden bit is mag[15]; the ten bits below it are the stored mantissa.
    fp16_round_rne u_round (
        .mant     (mag[14:5]),
        .exp      (exp_r),
        .guard    (mag[4]),
        .sticky   (|mag[3:0]),
        .mant_out (rnd_mant),
        .exp_out  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_ready   <= 1'b1;
            o_res     <= 16'h0000;
            o_res_vld <= 1'b0;
            o_inexact <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            mag       <= 16'h0000;
            exp_r     <= '0;
        end else begin
            o_res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        sign    <= i_int[15];
                        // -32768 negates to 16'h8000, which is its correct magnitude.
                        mag     <= i_int[15] ? 16'(~i_int + 16'd1) : i_int;
                        exp_r   <= EXP_W'(MAX_EXP);
                        zero    <= 1'b0;
                        o_ready <= 1'b0;
                        state   <= NORM;
                    end
                end
                NORM: begin
                    if (mag == 16'h0000) begin
                        zero  <= 1'b1;
                        state <= ROUND;
                    end else if (mag[15]) begin
                        state <= ROUND;
                    end else begin
                        mag   <= {mag[14:0], 1'b0};
                        exp_r <= exp_r - EXP_W'(1);
                    end
                end
                ROUND: begin
                    o_res     <= zero ? 16'h0000 : fp16_pack(sign, rnd_exp, rnd_mant);
                    o_inexact <= zero ? 1'b0 : rnd_inexact;
                    o_res_vld <= 1'b1;
                    o_ready   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/int16_to_fp16_serial.md
Name: int16_to_fp16_serial

Overview:
- Iterative converter from signed 16-bit two's-complement integers to IEEE 754 half-precision values.
- Produces encoded fp16 operands for the fp16 adder/subtractor datapath. It is the encoding side of the same number format.
- Normalises by shifting one bit per cycle, then rounds to nearest, ties to even.
- Uses a ready/valid input handshake and a one-cycle result-valid pulse, matching the adder's output style.

Parameters:
- EXP_BIAS, 15, fp16 exponent bias.
- MAX_EXP, 30, biased exponent for an operand whose magnitude MSB sits at bit 15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- i_valid  input  1  input integer valid.
- o_ready  output  1  converter idle and able to accept.
- i_int  input  16  signed two's-complement integer.
- o_res  output  16  fp16 result {sign, exp[4:0], mant[9:0]}.
- o_res_vld  output  1  one-cycle pulse; o_res is valid.
- o_inexact  output  1  result was rounded; valid with o_res_vld.

Behaviour:
- Reset is sampled on the rising edge while rst_n=0.
  - State goes to IDLE.
  - o_res=16'h0000, o_res_vld=0, o_inexact=0, o_ready=1.
  - Reset aborts any conversion in progress; no result is emitted.
- o_ready is 1 only in IDLE. i_valid while o_ready=0 is ignored and nothing is queued.
- FSM states: IDLE, NORM, ROUND.
- IDLE, on an edge with i_valid && o_ready (the accept edge):
  - sign <= i_int[15].
  - mag <= |i_int|, a 16-bit unsigned value. -32768 gives 16'h8000 with no overflow.
  - exp <= MAX_EXP.
  - Next state NORM.
- NORM:
  - If mag==0: set a zero flag and go to ROUND.
  - Else if mag[15]==1: go to ROUND.
  - Else: mag <= mag<<1, exp <= exp-1, stay in NORM. At most 15 shifts.
- ROUND (one cycle), with the hidden bit mag[15]:
  - mant = mag[14:5], guard = mag[4], sticky = |mag[3:0].
  - Round up when guard && (sticky || mant[0]).
  - If the increment carries out of mant: mant=0 and exp+1. A finite exponent ≤30 is guaranteed, so no infinity or overflow path exists.
  - Result registered: o_res <= {sign, exp, mant}, o_inexact <= guard|sticky, o_res_vld <= 1.
  - Zero case: o_res <= 16'h0000 (+0; integers have no -0), o_inexact <= 0.
  - Next state IDLE.
- o_res_vld is 0 in every cycle except the one following the ROUND edge. o_res and o_inexact hold their values until the next result.
- Latency:
  - For a nonzero input whose magnitude MSB is at bit p: o_res_vld rises (15-p)+2 edges after the accept edge.
  - Zero: 2 edges.
  - Range 2..17 edges.
- Back-to-back: o_ready=1 during the o_res_vld cycle, so the next accept can coincide with the result pulse. Throughput is one result per (latency+1) cycles at best.
- An accept with simultaneous reset: reset wins.

Decomposition:
- Shared package fp16_pkg:
  - Field widths: EXP_W=5, MANT_W=10.
  - EXP_BIAS=15 and the exp-all-ones constant.
  - State enum {IDLE, NORM, ROUND}.
  - The fp16 field-pack helper, shared with the adder's result packing.
- One natural sub-module: fp16_round_rne.
  - Combinational.
  - Inputs: mant[9:0], exp[4:0], guard, sticky.
  - Outputs: rounded mant and exp, plus inexact.
  - Reusable by later fp16 multiplier and divider blocks.

Test Plan:
- i_int=16'h0001 -> o_res=16'h3C00, o_inexact=0, o_res_vld 17 edges after accept.
- i_int=16'hFFFE (-2) -> o_res=16'hC000. i_int=16'h8000 (-32768) -> o_res=16'hF800, latency 2. i_int=0 -> o_res=16'h0000, latency 2.
- Rounding:
  - i_int=32767 -> o_res=16'h7800, o_inexact=1 (mantissa carry, exp 29->30).
  - i_int=2049 -> 16'h6800, inexact=1 (tie to even, down).
  - i_int=2051 -> 16'h6802, inexact=1 (tie, up).
- Handshake:
  - Hold i_valid=1 across three inputs (1, 2, 3) -> o_ready drops for each conversion.
  - Results 0x3C00, 0x4000, 0x4200 in order; each o_res_vld exactly one cycle.
  - Inputs presented while busy are not consumed.
- Reset mid-op: accept i_int=1, drive rst_n=0 at the 5th edge -> no o_res_vld pulse, o_res=0, o_ready=1 the next cycle.
- Then accept i_int=-1 -> 16'hBC00.
- Random sweep of all 65536 inputs against a reference model -> exact o_res and o_inexact match.
